tbus_arbiter: RTL and testbench

Two-requester arbiter sharing the single trinity-bus (tbus) port into the dcache between the instruction fetch unit (requester 0) and the memblock/load-store unit (requester 1). One transaction is owned at a time, from index handshake through `operation_done`. The pick rule is round-robin, and a grant is held until completion. The block sits between the frontend/memblock tbus channels and the dcache tbus slave.

---
 rtl/tbus_arbiter.sv | 117 +++++++++++
 tb/tb_tbus_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbus_arbiter.sv
// Round-robin arbiter sharing one tbus port into the dcache between fetch (0) and memblock (1).
// A grant is held from index handshake through operation_done.
module tbus_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned MASK_W = 64,
    parameter int unsigned OPT_W  = 2
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_index_valid,
    output logic              req0_index_ready,
    input  logic [DATA_W-1:0] req0_index,
    input  logic [DATA_W-1:0] req0_write_data,
    input  logic [MASK_W-1:0] req0_write_mask,
    input  logic [OPT_W-1:0]  req0_operation_type,
    output logic [DATA_W-1:0] req0_read_data,
    output logic              req0_operation_done,

    input  logic              req1_index_valid,
    output logic              req1_index_ready,
    input  logic [DATA_W-1:0] req1_index,
    input  logic [DATA_W-1:0] req1_write_data,
    input  logic [MASK_W-1:0] req1_write_mask,
    input  logic [OPT_W-1:0]  req1_operation_type,
    output logic [DATA_W-1:0] req1_read_data,
    output logic              req1_operation_done,

    output logic              arb2dcache_index_valid,
    input  logic              arb2dcache_index_ready,
    output logic [DATA_W-1:0] arb2dcache_index,
    output logic [DATA_W-1:0] arb2dcache_write_data,
    output logic [MASK_W-1:0] arb2dcache_write_mask,
    output logic [OPT_W-1:0]  arb2dcache_operation_type,
    input  logic [DATA_W-1:0] arb2dcache_read_data,
    input  logic              arb2dcache_operation_done,

    output logic              arb_busy
);

    typedef enum logic [1:0] {StIdle, StGrant, StWait} state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q, last_d;
    logic   sel_valid;
    logic   handshake;
    logic   complete;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign sel_valid = grant_q ? req1_index_valid : req0_index_valid;
    assign handshake = (state_q == StGrant) && sel_valid && arb2dcache_index_ready;
    // Done in the handshake cycle itself also completes the transaction.
    assign complete  = arb2dcache_operation_done && ((state_q == StWait) || handshake);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = complete ? grant_q : last_q;
        unique case (state_q)
            StIdle: begin
                if (req0_index_valid || req1_index_valid) begin
                    grant_d = (req0_index_valid && req1_index_valid) ? ~last_q : req1_index_valid;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                // Requester withdrew before the handshake: release without touching last_q.
                if (!sel_valid) begin
                    state_d = StIdle;
                end else if (handshake) begin
                    state_d = arb2dcache_operation_done ? StIdle : StWait;
                end
            end
            StWait: begin
                if (arb2dcache_operation_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        arb_busy               = (state_q != StIdle);
        arb2dcache_index_valid = (state_q == StGrant) && sel_valid;
        req0_index_ready       = (state_q == StGrant) && !grant_q && arb2dcache_index_ready;
        req1_index_ready       = (state_q == StGrant) && grant_q && arb2dcache_index_ready;
        req0_operation_done    = complete && !grant_q;
        req1_operation_done    = complete && grant_q;
        req0_read_data         = req0_operation_done ? arb2dcache_read_data : '0;
        req1_read_data         = req1_operation_done ? arb2dcache_read_data : '0;

        arb2dcache_index          = '0;
        arb2dcache_write_data     = '0;
        arb2dcache_write_mask     = '0;
        arb2dcache_operation_type = '0;
        if (state_q != StIdle) begin
            arb2dcache_index          = grant_q ? req1_index : req0_index;
            arb2dcache_write_data     = grant_q ? req1_write_data : req0_write_data;
            arb2dcache_write_mask     = grant_q ? req1_write_mask : req0_write_mask;
            arb2dcache_operation_type = grant_q ? req1_operation_type : req0_operation_type;
        end
    end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Directed plus randomized bench for tbus_arbiter, checked against a transaction-level model.
module tb_tbus_arbiter;

    logic        clock;
    logic        rst;
    logic        v     [2];
    logic [63:0] idx   [2];
    logic [63:0] wd    [2];
    logic [63:0] wm    [2];
    logic [1:0]  op    [2];
    logic        rdy   [2];
    logic        dn    [2];
    logic [63:0] rd    [2];
    logic        dc_valid, dc_ready, dc_done, busy;
    logic [63:0] dc_index, dc_wd, dc_wm, dc_rd;
    logic [1:0]  dc_op;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner is -1 when idle; acc marks that the index was accepted downstream.
    int owner = -1;
    bit acc   = 1'b0;
    int last  = 1;

    tbus_arbiter dut (
        .clock                     (clock),
        .reset                     (rst),
        .req0_index_valid          (v[0]),
        .req0_index_ready          (rdy[0]),
        .req0_index                (idx[0]),
        .req0_write_data           (wd[0]),
        .req0_write_mask           (wm[0]),
        .req0_operation_type       (op[0]),
        .req0_read_data            (rd[0]),
        .req0_operation_done       (dn[0]),
        .req1_index_valid          (v[1]),
        .req1_index_ready          (rdy[1]),
        .req1_index                (idx[1]),
        .req1_write_data           (wd[1]),
        .req1_write_mask           (wm[1]),
        .req1_operation_type       (op[1]),
        .req1_read_data            (rd[1]),
        .req1_operation_done       (dn[1]),
        .arb2dcache_index_valid    (dc_valid),
        .arb2dcache_index_ready    (dc_ready),
        .arb2dcache_index          (dc_index),
        .arb2dcache_write_data     (dc_wd),
        .arb2dcache_write_mask     (dc_wm),
        .arb2dcache_operation_type (dc_op),
        .arb2dcache_read_data      (dc_rd),
        .arb2dcache_operation_done (dc_done),
        .arb_busy                  (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; idx[i] = '0; wd[i] = '0; wm[i] = '0; op[i] = '0;
        end
        dc_ready = 1'b0; dc_done = 1'b0; dc_rd = '0;
    endtask

    // Compare every output against the model for the current inputs.
    task automatic check_outputs();
        logic ev, er, ed;
        #1;
        ev = (owner >= 0) && !acc && v[owner];
        chk("busy", 64'(busy), 64'(owner >= 0));
        chk("dc_valid", 64'(dc_valid), 64'(ev));
        for (int i = 0; i < 2; i++) begin
            er = (owner == i) && !acc && dc_ready;
            ed = (owner == i) && dc_done && (acc || (v[i] && dc_ready));
            chk($sformatf("ready%0d", i), 64'(rdy[i]), 64'(er));
            chk($sformatf("done%0d", i), 64'(dn[i]), 64'(ed));
            chk($sformatf("rdata%0d", i), rd[i], ed ? dc_rd : 64'h0);
        end
        if ((owner >= 0) && !acc) begin
            chk("fwd_index", dc_index, idx[owner]);
            chk("fwd_wdata", dc_wd, wd[owner]);
            chk("fwd_wmask", dc_wm, wm[owner]);
            chk("fwd_op", 64'(dc_op), 64'(op[owner]));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (rst) begin
            owner = -1; acc = 1'b0; last = 1;
        end else if (owner < 0) begin
            if (v[0] || v[1]) owner = (v[0] && v[1]) ? 1 - last : (v[1] ? 1 : 0);
            acc = 1'b0;
        end else if (!acc) begin
            if (!v[owner]) begin
                owner = -1;
            end else if (dc_ready) begin
                if (dc_done) begin
                    last = owner; owner = -1;
                end else begin
                    acc = 1'b1;
                end
            end
        end else if (dc_done) begin
            last = owner; owner = -1; acc = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic step();
        check_outputs();
        tick();
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_valid"}, 64'(dc_valid), 64'h0);
        chk({tag, "_index"}, dc_index, 64'h0);
        chk({tag, "_rdy"}, 64'({rdy[0], rdy[1]}), 64'h0);
        chk({tag, "_done"}, 64'({dn[0], dn[1]}), 64'h0);
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_outputs();
        all_zero("reset");
    endtask

    localparam logic [63:0] A0 = 64'h0000_0000_4000_0100;
    localparam logic [63:0] A1 = 64'h0000_0000_4000_0200;

    initial begin
        clr();
        rst = 1'b1;
        tick();

        // Single read on requester 1.
        do_reset();
        tick();
        v[1] = 1'b1; idx[1] = 64'h8000_1000; op[1] = 2'd0;
        check_outputs(); chk("rd_n_valid", 64'(dc_valid), 64'h0); tick();
        dc_ready = 1'b1;
        check_outputs(); chk("rd_fwd_valid", 64'(dc_valid), 64'h1);
        chk("rd_fwd_index", dc_index, 64'h8000_1000); tick();
        v[1] = 1'b0; dc_ready = 1'b0;
        step();
        dc_done = 1'b1; dc_rd = 64'hDEAD_BEEF_CAFE_F00D;
        check_outputs(); chk("rd_done1", 64'(dn[1]), 64'h1);
        chk("rd_data1", rd[1], 64'hDEAD_BEEF_CAFE_F00D); chk("rd_done0", 64'(dn[0]), 64'h0); tick();
        dc_done = 1'b0;
        check_outputs(); chk("rd_once", 64'(dn[1]), 64'h0); tick();

        // Tie after reset: 0 first, then 1, then 0 again.
        do_reset();
        v[0] = 1'b1; v[1] = 1'b1; idx[0] = A0; idx[1] = A1;
        step();
        dc_ready = 1'b1;
        check_outputs(); chk("tie1_index", dc_index, A0); tick();
        v[0] = 1'b0; dc_ready = 1'b0;
        step();
        dc_done = 1'b1; dc_rd = 64'h55;
        check_outputs(); chk("tie1_done0", 64'(dn[0]), 64'h1); tick();
        dc_done = 1'b0;
        check_outputs(); chk("tie2_gap", 64'(dc_valid), 64'h0); tick();
        dc_ready = 1'b1; dc_done = 1'b1;
        check_outputs(); chk("tie2_valid", 64'(dc_valid), 64'h1);
        chk("tie2_index", dc_index, A1); chk("tie2_done1", 64'(dn[1]), 64'h1); tick();
        v[0] = 1'b1; dc_ready = 1'b0; dc_done = 1'b0;
        step();
        dc_ready = 1'b1; dc_done = 1'b1;
        check_outputs(); chk("tie3_index", dc_index, A0); tick();

        // Store forwarding on requester 1 (last_id is now 0, so 1 wins the tie).
        dc_ready = 1'b0; dc_done = 1'b0;
        idx[0] = 64'h0BAD; wd[0] = 64'hFFFF; wm[0] = 64'hFF; op[0] = 2'd2;
        idx[1] = 64'h8000_0008; wd[1] = 64'h1122_3344 << 32;
        wm[1] = 64'hFFFF_FFFF_0000_0000; op[1] = 2'd1;
        step();
        for (int c = 0; c < 2; c++) begin
            dc_ready = (c == 1);
            check_outputs();
            chk("st_index", dc_index, 64'h8000_0008);
            chk("st_wdata", dc_wd, 64'h1122_3344_0000_0000);
            chk("st_wmask", dc_wm, 64'hFFFF_FFFF_0000_0000);
            chk("st_op", 64'(dc_op), 64'h1);
            tick();
        end

        // Abandon in GRANT leaves last_id untouched.
        do_reset();
        v[1] = 1'b1; idx[0] = A0; idx[1] = A1;
        step();
        step();
        v[1] = 1'b0;
        check_outputs(); chk("ab_valid", 64'(dc_valid), 64'h0); tick();
        v[0] = 1'b1; v[1] = 1'b1;
        check_outputs(); chk("ab_idle", 64'(busy), 64'h0); tick();
        check_outputs(); chk("ab_tie_index", dc_index, A0); tick();

        // Handshake and done in the same cycle.
        do_reset();
        v[0] = 1'b1; idx[0] = A0;
        step();
        dc_ready = 1'b1; dc_done = 1'b1; dc_rd = 64'h1234_5678;
        check_outputs(); chk("sc_done0", 64'(dn[0]), 64'h1);
        chk("sc_data0", rd[0], 64'h1234_5678); tick();
        clr();
        check_outputs(); chk("sc_idle", 64'(busy), 64'h0); tick();

        // Reset while waiting; a late done is ignored.
        v[1] = 1'b1; idx[1] = A1;
        step();
        dc_ready = 1'b1;
        step();
        v[1] = 1'b0; dc_ready = 1'b0;
        check_outputs(); chk("rw_wait", 64'(busy), 64'h1);
        rst = 1'b1; tick();
        rst = 1'b0;
        check_outputs(); all_zero("rw");
        dc_done = 1'b1; dc_rd = 64'h77;
        check_outputs(); chk("rw_late1", 64'(dn[1]), 64'h0); chk("rw_data1", rd[1], 64'h0); tick();
        clr();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(99) == 0);
            for (int i = 0; i < 2; i++) begin
                v[i]   = ($urandom_range(9) < 7);
                idx[i] = {$urandom, $urandom};
                wd[i]  = {$urandom, $urandom};
                wm[i]  = {$urandom, $urandom};
                op[i]  = 2'($urandom_range(3));
            end
            dc_ready = $urandom_range(1) == 1;
            dc_done  = ($urandom_range(9) < 3);
            dc_rd    = {$urandom, $urandom};
            if (!rst) check_outputs();
            else #1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
